vga_stream_monitor: RTL and testbench

- Passive receiver and checker for the VGA pixel stream: counts, syncs, blanks and RGB, as produced by `vga_timing` and passed through the overlay chain.
- Locks onto the incoming raster and compares every sample against an internally regenerated expected raster.
- Reports lock status, frame count, error count and first-error code.
- Sits at the tail of the drawing chain (after `pickups_management_unit`), in parallel with the VGA output pins; used on-chip and in simulation.

---
 rtl/vga_stream_monitor.sv | 236 +++++++++++++++++++++++
 tb/tb_vga_stream_monitor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_monitor.sv
`default_nettype none
// =============================================================================
// vga_stream_monitor : locks onto a VGA raster, checks every sample against a
// regenerated raster; VGA_MONITOR_CHECKSUM_EN adds the per-frame RGB checksum.
// Rev 1.0
// =============================================================================
module vga_stream_monitor #(
   parameter int H_TOTAL      = 1056,
   parameter int H_ACTIVE     = 800,
   parameter int H_SYNC_START = 840,
   parameter int H_SYNC_W     = 128,
   parameter int V_TOTAL      = 628,
   parameter int V_ACTIVE     = 600,
   parameter int V_SYNC_START = 601,
   parameter int V_SYNC_W     = 4,
   parameter int LOCK_FRAMES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic        hsync_in,
   input  logic        hblnk_in,
   input  logic [10:0] vcount_in,
   input  logic        vsync_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   output logic        locked,
   output logic        frame_pulse,
   output logic [15:0] frame_cnt,
   output logic        err_pulse,
   output logic [15:0] err_cnt,
   output logic        err_flag,
   output logic [2:0]  err_code,
   output logic [15:0] frame_sum
);
   localparam logic [1:0]  c_st_search = 2'd0;
   localparam logic [1:0]  c_st_track  = 2'd1;
   localparam logic [1:0]  c_st_locked = 2'd2;
   localparam logic [10:0] c_h_last    = 11'(H_TOTAL - 1);
   localparam logic [10:0] c_v_last    = 11'(V_TOTAL - 1);
   localparam logic [10:0] c_h_active  = 11'(H_ACTIVE);
   localparam logic [10:0] c_v_active  = 11'(V_ACTIVE);
   localparam logic [10:0] c_hs_start  = 11'(H_SYNC_START);
   localparam logic [10:0] c_hs_end    = 11'(H_SYNC_START + H_SYNC_W);
   localparam logic [10:0] c_vs_start  = 11'(V_SYNC_START);
   localparam logic [10:0] c_vs_end    = 11'(V_SYNC_START + V_SYNC_W);
   localparam logic [15:0] c_lock_last = 16'(LOCK_FRAMES - 1);

   logic        s1_vld_q, s1_vld_d;
   logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d;
   logic        hsync_q, hsync_d, hblnk_q, hblnk_d;
   logic        vsync_q, vsync_d, vblnk_q, vblnk_d;
   logic [10:0] eh_q, eh_d, ev_q, ev_d;
   logic [1:0]  state_q, state_d;
   logic [15:0] lock_cnt_q, lock_cnt_d;
   logic [15:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
   logic        err_flag_q, err_flag_d, frame_pulse_q, frame_pulse_d;
   logic        err_pulse_q, err_pulse_d;
   logic [2:0]  err_code_q, err_code_d;

   logic        w_exp_hsync, w_exp_hblnk, w_exp_vsync, w_exp_vblnk;
   logic        w_tracking, w_acquire, w_mismatch, w_frame_done;
   logic [2:0]  w_code;

   always_comb begin
      s1_vld_d = 1'b1;
      hcount_d = hcount_in;
      vcount_d = vcount_in;
      hsync_d  = hsync_in;
      hblnk_d  = hblnk_in;
      vsync_d  = vsync_in;
      vblnk_d  = vblnk_in;
   end

   assign w_exp_hsync  = (eh_q >= c_hs_start) && (eh_q < c_hs_end);
   assign w_exp_hblnk  = eh_q >= c_h_active;
   assign w_exp_vsync  = (ev_q >= c_vs_start) && (ev_q < c_vs_end);
   assign w_exp_vblnk  = ev_q >= c_v_active;
   assign w_tracking   = state_q != c_st_search;
   assign w_acquire    = s1_vld_q && !w_tracking && (hcount_q == 11'd0) && (vcount_q == 11'd0);
   assign w_mismatch   = w_tracking && (w_code != 3'd0);
   assign w_frame_done = w_tracking && (w_code == 3'd0) && (eh_q == c_h_last) && (ev_q == c_v_last);

   // Lowest code wins when several fields disagree in the same sample.
   always_comb begin
      w_code = 3'd0;
      if (hcount_q != eh_q)              w_code = 3'd1;
      else if (vcount_q != ev_q)         w_code = 3'd2;
      else if (hsync_q != w_exp_hsync)   w_code = 3'd3;
      else if (hblnk_q != w_exp_hblnk)   w_code = 3'd4;
      else if (vsync_q != w_exp_vsync)   w_code = 3'd5;
      else if (vblnk_q != w_exp_vblnk)   w_code = 3'd6;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_st_search: if (w_acquire) state_d = c_st_track;
         c_st_track: begin
            if (w_mismatch)
               state_d = c_st_search;
            else if (w_frame_done && (lock_cnt_q == c_lock_last))
               state_d = c_st_locked;
         end
         c_st_locked: if (w_mismatch) state_d = c_st_search;
         default:     state_d = c_st_search;
      endcase
   end

   always_comb begin
      eh_d          = eh_q;
      ev_d          = ev_q;
      lock_cnt_d    = lock_cnt_q;
      frame_cnt_d   = frame_cnt_q;
      err_cnt_d     = err_cnt_q;
      err_flag_d    = err_flag_q;
      err_code_d    = err_code_q;
      frame_pulse_d = 1'b0;
      err_pulse_d   = 1'b0;
      if (!w_tracking) begin
         lock_cnt_d = 16'd0;
         if (w_acquire) begin
            eh_d = 11'd1;
            ev_d = 11'd0;
         end
      end else begin
         eh_d = (eh_q == c_h_last) ? 11'd0 : eh_q + 11'd1;
         if (eh_q == c_h_last)
            ev_d = (ev_q == c_v_last) ? 11'd0 : ev_q + 11'd1;
         if (w_mismatch) begin
            err_pulse_d = 1'b1;
            err_flag_d  = 1'b1;
            lock_cnt_d  = 16'd0;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (!err_flag_q)           err_code_d = w_code;
         end else if (w_frame_done) begin
            if (state_q == c_st_locked) begin
               frame_pulse_d = 1'b1;
               frame_cnt_d   = frame_cnt_q + 16'd1;
            end else begin
               lock_cnt_d = lock_cnt_q + 16'd1;
            end
         end
      end
   end

   always_comb locked = (state_q == c_st_locked);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q      <= 1'b0;
         hcount_q      <= 11'd0;
         vcount_q      <= 11'd0;
         hsync_q       <= 1'b0;
         hblnk_q       <= 1'b0;
         vsync_q       <= 1'b0;
         vblnk_q       <= 1'b0;
         eh_q          <= 11'd0;
         ev_q          <= 11'd0;
         state_q       <= c_st_search;
         lock_cnt_q    <= 16'd0;
         frame_cnt_q   <= 16'd0;
         err_cnt_q     <= 16'd0;
         err_flag_q    <= 1'b0;
         err_code_q    <= 3'd0;
         frame_pulse_q <= 1'b0;
         err_pulse_q   <= 1'b0;
      end else begin
         s1_vld_q      <= s1_vld_d;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         hblnk_q       <= hblnk_d;
         vsync_q       <= vsync_d;
         vblnk_q       <= vblnk_d;
         eh_q          <= eh_d;
         ev_q          <= ev_d;
         state_q       <= state_d;
         lock_cnt_q    <= lock_cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         err_cnt_q     <= err_cnt_d;
         err_flag_q    <= err_flag_d;
         err_code_q    <= err_code_d;
         frame_pulse_q <= frame_pulse_d;
         err_pulse_q   <= err_pulse_d;
      end
   end

   assign frame_pulse = frame_pulse_q;
   assign frame_cnt   = frame_cnt_q;
   assign err_pulse   = err_pulse_q;
   assign err_cnt     = err_cnt_q;
   assign err_flag    = err_flag_q;
   assign err_code    = err_code_q;

`ifdef VGA_MONITOR_CHECKSUM_EN
   logic [11:0] rgb_q, rgb_d;
   logic [15:0] acc_q, acc_d, sum_q, sum_d;
   logic [15:0] w_pix;

   assign w_pix = (!hblnk_q && !vblnk_q) ? {4'd0, rgb_q} : 16'd0;

   // The completing sample's own contribution is folded into the published sum.
   always_comb begin
      rgb_d = rgb_in;
      acc_d = 16'd0;
      sum_d = sum_q;
      if (w_tracking && !w_mismatch) begin
         if (w_frame_done)
            sum_d = acc_q + w_pix;
         else
            acc_d = acc_q + w_pix;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q <= 12'd0;
         acc_q <= 16'd0;
         sum_q <= 16'd0;
      end else begin
         rgb_q <= rgb_d;
         acc_q <= acc_d;
         sum_q <= sum_d;
      end
   end

   assign frame_sum = sum_q;
`else
   logic unused_rgb;
   assign unused_rgb = ^rgb_in;
   assign frame_sum  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_stream_monitor.sv
`default_nettype none
// =============================================================================
// tb_vga_stream_monitor : randomized raster stimulus with fault injection,
// checked every cycle against a frame-position reference model.
// Rev 1.0
// =============================================================================
module tb_vga_stream_monitor;
   localparam int HT = 20, HA = 12, HSS = 14, HSW = 3;
   localparam int VT = 10, VA = 6, VSS = 7, VSW = 2;
   localparam int LF = 2;
   localparam int FRAME = HT * VT;

   typedef struct packed {
      logic [10:0] h;
      logic        hs;
      logic        hb;
      logic [10:0] v;
      logic        vs;
      logic        vb;
      logic [11:0] rgb;
   } smp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
   logic [11:0] rgb_in;
   logic        locked, frame_pulse, err_pulse, err_flag;
   logic [15:0] frame_cnt, err_cnt, frame_sum;
   logic [2:0]  err_code;

   always #5 clk = ~clk;

   vga_stream_monitor #(
      .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_W(HSW),
      .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_W(VSW),
      .LOCK_FRAMES(LF)
   ) dut (
      .clk(clk), .rst(rst),
      .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
      .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in),
      .locked(locked), .frame_pulse(frame_pulse), .frame_cnt(frame_cnt),
      .err_pulse(err_pulse), .err_cnt(err_cnt), .err_flag(err_flag),
      .err_code(err_code), .frame_sum(frame_sum)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: mode 0 search, 1 track, 2 locked; position is linear in the frame.
   int          m_mode, m_pos, m_lockn;
   logic [15:0] m_fcnt, m_ecnt, m_sum, m_acc;
   logic        m_flag, m_fp, m_ep;
   logic [2:0]  m_code;
   smp_t        prev;
   logic        prev_vld;
   int          gpos;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic smp_t ideal(input int pos);
      smp_t s;
      int   h, v;
      h     = pos % HT;
      v     = pos / HT;
      s.h   = 11'(h);
      s.v   = 11'(v);
      s.hs  = (h >= HSS) && (h < HSS + HSW);
      s.hb  = (h >= HA);
      s.vs  = (v >= VSS) && (v < VSS + VSW);
      s.vb  = (v >= VA);
      s.rgb = 12'd0;
      return s;
   endfunction

   function automatic smp_t corrupt(input smp_t s, input int k);
      smp_t r;
      r = s;
      case (k)
         0: r.h  = s.h ^ 11'd1;
         1: r.v  = s.v ^ 11'd1;
         2: r.hs = ~s.hs;
         3: r.hb = ~s.hb;
         4: r.vs = ~s.vs;
         5: r.vb = ~s.vb;
         default: begin
            r.h  = s.h ^ 11'd1;
            r.hs = ~s.hs;
         end
      endcase
      return r;
   endfunction

   function automatic logic [2:0] first_err(input smp_t s, input smp_t e);
      if (s.h != e.h)   return 3'd1;
      if (s.v != e.v)   return 3'd2;
      if (s.hs != e.hs) return 3'd3;
      if (s.hb != e.hb) return 3'd4;
      if (s.vs != e.vs) return 3'd5;
      if (s.vb != e.vb) return 3'd6;
      return 3'd0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_lockn = 0;
      m_fcnt = 16'd0; m_ecnt = 16'd0; m_sum = 16'd0; m_acc = 16'd0;
      m_flag = 1'b0; m_code = 3'd0; m_fp = 1'b0; m_ep = 1'b0;
   endtask

   task automatic model_process(input smp_t s);
      logic [2:0]  code;
      logic [15:0] add;
      if (m_mode == 0) begin
         if (s.h == 11'd0 && s.v == 11'd0) begin
            m_mode = 1; m_pos = 1; m_lockn = 0; m_acc = 16'd0;
         end
      end else begin
         code = first_err(s, ideal(m_pos));
         if (code != 3'd0) begin
            m_ep = 1'b1;
            if (m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
            if (!m_flag) m_code = code;
            m_flag = 1'b1;
            m_mode = 0;
            m_acc  = 16'd0;
         end else begin
            add = (!s.hb && !s.vb) ? {4'd0, s.rgb} : 16'd0;
            if (m_pos == FRAME - 1) begin
               if (m_mode == 2) begin
                  m_fp   = 1'b1;
                  m_fcnt = m_fcnt + 16'd1;
               end else begin
                  m_lockn++;
                  if (m_lockn == LF) m_mode = 2;
               end
               m_sum = m_acc + add;
               m_acc = 16'd0;
            end else begin
               m_acc = m_acc + add;
            end
            m_pos = (m_pos + 1) % FRAME;
         end
      end
   endtask

   task automatic step(input logic r, input smp_t s);
      logic [15:0] exp_sum;
      rst       = r;
      hcount_in = s.h;  hsync_in = s.hs; hblnk_in = s.hb;
      vcount_in = s.v;  vsync_in = s.vs; vblnk_in = s.vb;
      rgb_in    = s.rgb;
      @(posedge clk);
      #1;
      m_fp = 1'b0;
      m_ep = 1'b0;
      if (r) begin
         model_reset();
         prev_vld = 1'b0;
      end else begin
         if (prev_vld) model_process(prev);
         prev     = s;
         prev_vld = 1'b1;
      end
`ifdef VGA_MONITOR_CHECKSUM_EN
      exp_sum = m_sum;
`else
      exp_sum = 16'd0;
`endif
      chk("locked",      32'(locked),      32'(m_mode == 2));
      chk("frame_pulse", 32'(frame_pulse), 32'(m_fp));
      chk("frame_cnt",   32'(frame_cnt),   32'(m_fcnt));
      chk("err_pulse",   32'(err_pulse),   32'(m_ep));
      chk("err_cnt",     32'(err_cnt),     32'(m_ecnt));
      chk("err_flag",    32'(err_flag),    32'(m_flag));
      chk("err_code",    32'(err_code),    32'(m_code));
      chk("frame_sum",   32'(frame_sum),   32'(exp_sum));
   endtask

   task automatic run(input int n, input int permille);
      for (int i = 0; i < n; i++) begin
         smp_t s;
         s     = ideal(gpos);
         s.rgb = 12'($urandom);
         if (int'($urandom_range(999)) < permille)
            s = corrupt(s, int'($urandom_range(6)));
         step(1'b0, s);
         gpos = (gpos + 1) % FRAME;
      end
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < FRAME && gpos != target; i++) run(1, 0);
   endtask

   task automatic fault(input int k);
      smp_t s;
      s     = ideal(gpos);
      s.rgb = 12'($urandom);
      step(1'b0, corrupt(s, k));
      gpos = (gpos + 1) % FRAME;
   endtask

   initial begin
      smp_t s;
      rst = 1'b1;
      hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; hblnk_in = 1'b0;
      vsync_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;
      prev = '0; prev_vld = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) step(1'b1, ideal(0));

      // Clean stream from an arbitrary phase: acquire, lock, count frames.
      gpos = int'($urandom_range(FRAME - 1));
      run(4 * FRAME, 0);

      // Single hsync dropout while locked, then relock.
      run_to(2 * HT + HSS);
      fault(2);
      run(3 * FRAME + 5, 0);

      // Reset in the middle of a locked frame.
      run_to(5 * HT + 7);
      s = ideal(gpos);
      step(1'b1, s);
      gpos = (gpos + 1) % FRAME;
      run(3 * FRAME, 0);

      // hcount and hsync wrong together: first code must be hcount.
      run_to(3 * HT + 2);
      fault(6);
      run(2 * FRAME, 0);

      // Random fault soak.
      run(10 * FRAME, 4);

      // Error counter saturation after preloading near the top.
      run(3 * FRAME, 0);
      force dut.err_cnt_q = 16'hFFFD;
      #1;
      release dut.err_cnt_q;
      m_ecnt = 16'hFFFD;
      for (int i = 0; i < 5; i++) begin
         run(FRAME + 3, 0);
         fault(int'($urandom_range(5)));
      end
      run(2 * FRAME, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
